// File: rtl/pattern_pkg.sv
// Shared pattern indices, default dwell times, step limits and scheduler state type
// for the VGA demo pattern path.
package pattern_pkg;

    localparam logic [1:0] PATTERN_CHECKERBOARD = 2'd0;
    localparam logic [1:0] PATTERN_RADIENT      = 2'd1;
    localparam logic [1:0] PATTERN_SPIRAL       = 2'd2;

    localparam int NUM_PATTERNS = 3;

    localparam int FRAMES_P0    = 240;
    localparam int FRAMES_P1    = 480;
    localparam int FRAMES_P2    = 360;
    localparam int BLANK_FRAMES = 2;

    localparam logic [2:0] STEP_MIN = 3'd1;
    localparam logic [2:0] STEP_MAX = 3'd7;

    typedef enum logic {
        RUN   = 1'b0,
        BLANK = 1'b1
    } sched_state_e;

endpackage

// File: rtl/pattern_scheduler_btn_frame_edge.sv
// Raw button -> 2-flop synchronizer -> once-per-frame sample; press is a one-cycle
// pulse on the frame_tick where the sampled level goes 0->1.
module btn_frame_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic frame_tick,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;
    logic hist_d;

    // Sampling only on frame_tick gives a ~16.7 ms period, which is the debounce.
    always_comb begin
        hist_d = hist_q;
        if (frame_tick) begin
            hist_d = sync2_q;
        end
    end

    assign press = frame_tick & sync2_q & ~hist_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source, which is what makes the sync chain two deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
        end
    end

endmodule

// File: rtl/pattern_scheduler.sv
// Frame-synchronous VGA pattern scheduler: button/auto pattern selection, pause, step size.
// Define PATTERN_SCHED_FADE_EN to insert BLANK_FRAMES of forced blanking before each switch.
module pattern_scheduler #(
    parameter int NUM_PATTERNS = pattern_pkg::NUM_PATTERNS,
    parameter int FRAMES_P0    = pattern_pkg::FRAMES_P0,
    parameter int FRAMES_P1    = pattern_pkg::FRAMES_P1,
    parameter int FRAMES_P2    = pattern_pkg::FRAMES_P2,
    parameter int BLANK_FRAMES = pattern_pkg::BLANK_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_pause,
    input  logic       btn_speed,
    input  logic       auto_en,
    output logic [1:0] pattern_sel,
    output logic       animate,
    output logic       paused,
    output logic [2:0] step_size,
    output logic       blank
);

    import pattern_pkg::*;

    logic       vsync_q;
    logic       frame_tick;
    logic       next_press;
    logic       prev_press;
    logic       pause_press;
    logic       speed_press;

    logic [1:0] sel_q, sel_d;
    logic       paused_q, paused_d;
    logic [2:0] step_q, step_d;
    logic       animate_q, animate_d;
    logic [9:0] frame_cnt_q, frame_cnt_d;

    logic       next_req;
    logic       prev_req;
    logic       auto_req;
    logic       switch_req;
    logic [1:0] sel_inc;
    logic [1:0] sel_dec;
    logic [1:0] req_target;
    logic [9:0] dwell_last;

    // Rising edge of vsync marks the end of the sync pulse.
    assign frame_tick = vsync & ~vsync_q;

    btn_frame_edge u_btn_next  (.clk(clk), .rst(rst), .btn(btn_next),  .frame_tick(frame_tick), .press(next_press));
    btn_frame_edge u_btn_prev  (.clk(clk), .rst(rst), .btn(btn_prev),  .frame_tick(frame_tick), .press(prev_press));
    btn_frame_edge u_btn_pause (.clk(clk), .rst(rst), .btn(btn_pause), .frame_tick(frame_tick), .press(pause_press));
    btn_frame_edge u_btn_speed (.clk(clk), .rst(rst), .btn(btn_speed), .frame_tick(frame_tick), .press(speed_press));

    assign sel_inc = (sel_q == 2'(NUM_PATTERNS - 1)) ? 2'd0 : sel_q + 2'd1;
    assign sel_dec = (sel_q == 2'd0) ? 2'(NUM_PATTERNS - 1) : sel_q - 2'd1;

    always_comb begin
        case (sel_q)
            2'd0:    dwell_last = 10'(FRAMES_P0 - 1);
            2'd1:    dwell_last = 10'(FRAMES_P1 - 1);
            default: dwell_last = 10'(FRAMES_P2 - 1);
        endcase
    end

    // Simultaneous next+prev cancel out and count as no button request.
    assign next_req   = next_press & ~prev_press;
    assign prev_req   = prev_press & ~next_press;
    assign auto_req   = auto_en & ~paused_q & ~next_req & ~prev_req & (frame_cnt_q == dwell_last);
    assign switch_req = next_req | prev_req | auto_req;
    assign req_target = prev_req ? sel_dec : sel_inc;

`ifdef PATTERN_SCHED_FADE_EN
    sched_state_e state_q, state_d;
    logic [1:0]   target_q, target_d;
    logic [3:0]   blank_cnt_q, blank_cnt_d;
    logic         blank_q, blank_d;
`else
    logic [3:0]   unused_blank_frames;
    assign unused_blank_frames = 4'(BLANK_FRAMES);
`endif

    // NOTE: every _d starts from its hold value so no path through this block
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_d       = sel_q;
        paused_d    = paused_q;
        step_d      = step_q;
        frame_cnt_d = frame_cnt_q;
        animate_d   = 1'b0;
`ifdef PATTERN_SCHED_FADE_EN
        state_d     = state_q;
        target_d    = target_q;
        blank_cnt_d = blank_cnt_q;
        blank_d     = blank_q;
`endif
        if (frame_tick) begin
            if (pause_press) begin
                paused_d = ~paused_q;
            end
            if (speed_press) begin
                step_d = (step_q == STEP_MAX) ? STEP_MIN : step_q + 3'd1;
            end
`ifdef PATTERN_SCHED_FADE_EN
            case (state_q)
                RUN: begin
                    if (switch_req) begin
                        state_d     = BLANK;
                        target_d    = req_target;
                        blank_cnt_d = 4'(BLANK_FRAMES - 1);
                        blank_d     = 1'b1;
                    end else if (!paused_q) begin
                        frame_cnt_d = frame_cnt_q + 10'd1;
                        animate_d   = 1'b1;
                    end
                end
                BLANK: begin
                    // Next/prev presses are consumed here without effect.
                    if (blank_cnt_q == 4'd0) begin
                        sel_d       = target_q;
                        frame_cnt_d = 10'd0;
                        blank_d     = 1'b0;
                        state_d     = RUN;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 4'd1;
                    end
                end
                default: state_d = RUN;
            endcase
`else
            if (switch_req) begin
                sel_d       = req_target;
                frame_cnt_d = 10'd0;
            end else if (!paused_q) begin
                frame_cnt_d = frame_cnt_q + 10'd1;
                animate_d   = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q     <= 1'b1;
            sel_q       <= PATTERN_CHECKERBOARD;
            paused_q    <= 1'b0;
            step_q      <= STEP_MIN;
            animate_q   <= 1'b0;
            frame_cnt_q <= 10'd0;
`ifdef PATTERN_SCHED_FADE_EN
            state_q     <= RUN;
            target_q    <= PATTERN_CHECKERBOARD;
            blank_cnt_q <= 4'd0;
            blank_q     <= 1'b0;
`endif
        end else begin
            vsync_q     <= vsync;
            sel_q       <= sel_d;
            paused_q    <= paused_d;
            step_q      <= step_d;
            animate_q   <= animate_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef PATTERN_SCHED_FADE_EN
            state_q     <= state_d;
            target_q    <= target_d;
            blank_cnt_q <= blank_cnt_d;
            blank_q     <= blank_d;
`endif
        end
    end

    assign pattern_sel = sel_q;
    assign animate     = animate_q;
    assign paused      = paused_q;
    assign step_size   = step_q;
`ifdef PATTERN_SCHED_FADE_EN
    assign blank       = blank_q;
`else
    assign blank       = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench for pattern_scheduler: frame-level reference model, a speed-press
// vector table, hand-written corner sequences and a randomized button soak.
module tb_pattern_scheduler;

`ifdef PATTERN_SCHED_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif
    localparam int NPAT   = 3;
    localparam int NBLANK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync;
    logic       btn_next, btn_prev, btn_pause, btn_speed, auto_en;
    logic [1:0] pattern_sel;
    logic       animate, paused, blank;
    logic [2:0] step_size;

    pattern_scheduler #(
        .NUM_PATTERNS(NPAT), .FRAMES_P0(240), .FRAMES_P1(480), .FRAMES_P2(360), .BLANK_FRAMES(NBLANK)
    ) dut (
        .clk(clk), .rst(rst), .vsync(vsync),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_pause(btn_pause), .btn_speed(btn_speed),
        .auto_en(auto_en), .pattern_sel(pattern_sel), .animate(animate), .paused(paused),
        .step_size(step_size), .blank(blank)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level view of the scheduler.
    int m_dwell[NPAT] = '{240, 480, 360};
    int m_sel, m_step, m_cnt, m_left, m_target;
    bit m_paused, m_in_blank, m_anim;
    bit h_next, h_prev, h_pause, h_speed;

    task automatic model_reset();
        m_sel = 0; m_step = 1; m_cnt = 0; m_left = 0; m_target = 0;
        m_paused = 0; m_in_blank = 0; m_anim = 0;
        h_next = 0; h_prev = 0; h_pause = 0; h_speed = 0;
    endtask

    task automatic model_tick(input bit n, input bit p, input bit pa, input bit sp, input bit au);
        bit np, pp, pap, spp, was_paused;
        int req;
        np = n & !h_next;   h_next  = n;
        pp = p & !h_prev;   h_prev  = p;
        pap = pa & !h_pause; h_pause = pa;
        spp = sp & !h_speed; h_speed = sp;
        was_paused = m_paused;
        m_anim = 0;
        if (pap) m_paused = !m_paused;
        if (spp) m_step = (m_step % 7) + 1;
        if (m_in_blank) begin
            if (m_left == 1) begin
                m_sel = m_target; m_cnt = 0; m_in_blank = 0;
            end else begin
                m_left--;
            end
        end else begin
            req = -1;
            if (np && !pp)      req = (m_sel + 1) % NPAT;
            else if (pp && !np) req = (m_sel + NPAT - 1) % NPAT;
            else if (au && !was_paused && m_cnt == m_dwell[m_sel] - 1) req = (m_sel + 1) % NPAT;
            if (req >= 0) begin
                if (FADE) begin
                    m_in_blank = 1; m_left = NBLANK; m_target = req;
                end else begin
                    m_sel = req; m_cnt = 0;
                end
            end else if (!was_paused) begin
                m_cnt = (m_cnt + 1) % 1024;
                m_anim = 1;
            end
        end
    endtask

    // One video frame: drive buttons, pulse vsync, compare everything after the tick edge.
    task automatic frame(input bit n, input bit p, input bit pa, input bit sp, input bit au,
                         output bit anim_seen);
        btn_next = n; btn_prev = p; btn_pause = pa; btn_speed = sp; auto_en = au;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        model_tick(n, p, pa, sp, au);
        @(negedge clk);
        anim_seen = animate;
        check("animate", int'(animate), int'(m_anim));
        check("pattern_sel", int'(pattern_sel), m_sel);
        check("paused", int'(paused), int'(m_paused));
        check("step_size", int'(step_size), m_step);
        check("blank", int'(blank), int'(m_in_blank));
        @(negedge clk);
        check("animate_one_cycle", int'(animate), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn_next = 0; btn_prev = 0; btn_pause = 0; btn_speed = 0; vsync = 1'b1;
        #1;
        check("rst_pattern_sel", int'(pattern_sel), 0);
        check("rst_animate", int'(animate), 0);
        check("rst_paused", int'(paused), 0);
        check("rst_step_size", int'(step_size), 1);
        check("rst_blank", int'(blank), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit spd;
        int exp_step;
        int exp_sel;
        bit exp_anim;
    } vec_t;

    vec_t tbl[14];

    initial begin
        bit a;
        int anim_hits;
        int waited;
        bit ln, lp, lpa, lsp, lau;

        for (int k = 0; k < 14; k++) begin
            tbl[k].spd      = (k % 2 == 0);
            tbl[k].exp_step = ((k / 2 + 1) % 7) + 1;
            tbl[k].exp_sel  = 0;
            tbl[k].exp_anim = 1'b1;
        end

        rst = 1'b1; vsync = 1'b1; auto_en = 1'b0;
        btn_next = 0; btn_prev = 0; btn_pause = 0; btn_speed = 0;
        model_reset();
        do_reset();

        // Auto-advance after 240 frames of pattern 0.
        for (int f = 1; f < 240; f++) frame(0, 0, 0, 0, 1, a);
        check("auto_before_dwell_sel", int'(pattern_sel), 0);
        anim_hits = 0;
        frame(0, 0, 0, 0, 1, a); anim_hits += int'(a);
        check("auto_f240_blank", int'(blank), int'(FADE));
        check("auto_f240_sel", int'(pattern_sel), FADE ? 0 : 1);
        frame(0, 0, 0, 0, 1, a); if (FADE) anim_hits += int'(a);
        check("auto_f241_blank", int'(blank), int'(FADE));
        frame(0, 0, 0, 0, 1, a); if (FADE) anim_hits += int'(a);
        check("auto_f242_sel", int'(pattern_sel), 1);
        check("auto_f242_blank", int'(blank), 0);
        check("auto_no_anim_in_blank", anim_hits, 0);

        // Prev wrap from 0 to 2; holding the button gives only one switch.
        do_reset();
        frame(0, 1, 0, 0, 0, a);
        check("prev_press_blank", int'(blank), int'(FADE));
        for (int f = 0; f < 5; f++) frame(0, 1, 0, 0, 0, a);
        check("prev_wrap_sel", int'(pattern_sel), 2);
        check("prev_held_no_blank", int'(blank), 0);
        frame(0, 0, 0, 0, 0, a);

        // Pause freezes selection and animation under auto_en for 600 frames.
        frame(0, 0, 1, 0, 1, a);
        frame(0, 0, 0, 0, 1, a);
        anim_hits = 0;
        for (int f = 0; f < 600; f++) begin
            frame(0, 0, 0, 0, 1, a);
            anim_hits += int'(a);
        end
        check("pause_state", int'(paused), 1);
        check("pause_sel_held", int'(pattern_sel), 2);
        check("pause_no_anim", anim_hits, 0);
        frame(0, 0, 1, 0, 1, a);
        check("resume_state", int'(paused), 0);
        waited = 0;
        while (pattern_sel != 2'd0 && waited < 400) begin
            frame(0, 0, 0, 0, 1, a);
            waited++;
        end
        check("resume_auto_switch", int'(pattern_sel), 0);

        // Speed presses from reset, one press every other frame.
        do_reset();
        foreach (tbl[k]) begin
            frame(1'b0, 1'b0, 1'b0, tbl[k].spd, 1'b0, a);
            check($sformatf("tbl%0d_step", k), int'(step_size), tbl[k].exp_step);
            check($sformatf("tbl%0d_sel", k), int'(pattern_sel), tbl[k].exp_sel);
            check($sformatf("tbl%0d_anim", k), int'(a), int'(tbl[k].exp_anim));
        end

        // Next and prev rising together cancel.
        frame(1, 1, 0, 0, 0, a);
        check("both_no_blank", int'(blank), 0);
        check("both_sel", int'(pattern_sel), 0);
        check("both_anim", int'(a), 1);
        frame(0, 0, 0, 0, 0, a);

        // Reset lands during the first blanking frame; the pending target is dropped.
        frame(0, 0, 0, 1, 0, a);
        frame(1, 0, 0, 0, 0, a);
        check("next_same_tick_sel", int'(pattern_sel), FADE ? 0 : 1);
        check("next_blank", int'(blank), int'(FADE));
        do_reset();
        for (int f = 0; f < 3; f++) frame(0, 0, 0, 0, 0, a);
        check("post_rst_sel", int'(pattern_sel), 0);
        check("post_rst_blank", int'(blank), 0);

        // Randomized soak: busy buttons first, then mostly quiet to let auto-advance fire.
        ln = 0; lp = 0; lpa = 0; lsp = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i < 700) begin
                if ($urandom_range(7) == 0)  ln  = ~ln;
                if ($urandom_range(7) == 0)  lp  = ~lp;
                if ($urandom_range(15) == 0) lpa = ~lpa;
            end else begin
                if ($urandom_range(63) == 0)  ln  = ~ln;
                if ($urandom_range(63) == 0)  lp  = ~lp;
                if ($urandom_range(199) == 0) lpa = ~lpa;
            end
            if ($urandom_range(5) == 0) lsp = ~lsp;
            lau = ($urandom_range(9) != 0);
            frame(ln, lp, lpa, lsp, lau, a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_scheduler.md
Name: pattern_scheduler

Overview:
- Control block that sequences the VGA demo patterns. It owns pattern selection, the per-pattern dwell timer, pause state, animation step size and transition blanking.
- Inputs are vsync and four user buttons. Outputs are the pattern index and per-frame animation strobe consumed by the pattern generators and output mux.
- Replaces free-running selection logic with a button-driven, frame-synchronous scheduler.

Parameters:
- NUM_PATTERNS, 3, number of patterns cycled; indices 0..NUM_PATTERNS-1.
- FRAMES_P0, 240, dwell frames for pattern 0.
- FRAMES_P1, 480, dwell frames for pattern 1.
- FRAMES_P2, 360, dwell frames for pattern 2.
- BLANK_FRAMES, 2, frames of forced blanking before a switch; 1..15.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- vsync  in  1  VGA vsync, active low
- btn_next  in  1  raw async button, active high
- btn_prev  in  1  raw async button, active high
- btn_pause  in  1  raw async button, toggles pause
- btn_speed  in  1  raw async button, cycles step size
- auto_en  in  1  enables timed auto-advance
- pattern_sel  out  2  active pattern index
- animate  out  1  one-cycle per-frame animation strobe
- paused  out  1  pause state
- step_size  out  3  animation step, range 1..7
- blank  out  1  forces black output during a transition

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset values: pattern_sel=0, animate=0, paused=0, step_size=1, blank=0, frame_cnt=0, state=RUN, vsync_q=1, all button history=0.
- Frame tick:
  - vsync_q is a register of vsync.
  - frame_tick = vsync & ~vsync_q, i.e. the end of the vsync pulse.
  - All scheduler state changes occur only on clk edges where frame_tick=1.
- Buttons:
  - Each button passes through a 2-flop synchronizer.
  - The synchronized level is sampled only on frame_tick (a 16.7 ms sample period, which acts as the debounce).
  - A press is a 0->1 change between consecutive frame samples, so at most one press is registered per button per frame.
- Pause: a press toggles paused in any state.
- Speed: a press sets step_size = step_size+1, wrapping 7->1. step_size is never 0.
- Dwell counter:
  - frame_cnt is 10 bits.
  - It increments on frame_tick in RUN when not paused.
  - It holds while paused or in BLANK.
  - It clears to 0 on every pattern switch.
- Switch request, evaluated on frame_tick in RUN:
  - next press and no prev press: target = sel+1, wrapping NUM_PATTERNS-1 -> 0.
  - prev press and no next press: target = sel-1, wrapping 0 -> NUM_PATTERNS-1.
  - next and prev pressed on the same frame: both are ignored.
  - Auto request: auto_en=1, not paused, no button request, and frame_cnt == dwell(sel)-1. Target = sel+1 with the same wrap.
  - Manual requests are honoured while paused.
- State machine, states RUN and BLANK:
  - RUN -> BLANK on a request. Latch target, set blank_cnt=BLANK_FRAMES-1, assert blank=1.
  - In BLANK, on each frame_tick: if blank_cnt==0, then pattern_sel<=target, frame_cnt<=0, blank<=0, go to RUN. Otherwise decrement blank_cnt.
  - next/prev presses during BLANK are discarded; pause and speed presses still act.
- animate:
  - Registered; high for exactly the one cycle after a frame_tick edge.
  - Requires RUN, not paused, and no switch taken on that tick.
  - Never high while blank=1.
- Reset mid-BLANK: outputs return to reset values immediately; the pending target is lost.

Optional Feature:
- Macro PATTERN_SCHED_FADE_EN.
- Defined: BLANK state and the blank output behave as above.
- Undefined: no BLANK state. A request switches pattern_sel on the same frame_tick and clears frame_cnt. blank is tied to 0, and BLANK_FRAMES is unused.

Decomposition:
- Shared package pattern_pkg holds:
  - PATTERN_CHECKERBOARD=0, PATTERN_RADIENT=1, PATTERN_SPIRAL=2
  - NUM_PATTERNS
  - default dwell frame constants
  - STEP_MIN=1, STEP_MAX=7
  - the scheduler state enum
- Sub-module btn_frame_edge: 2FF synchronizer, frame-sampled history register and press pulse output. Instantiated 4 times.

Test Plan:
- Reset, auto_en=1, no buttons, 240 frames -> BLANK for 2 frames with blank=1, then pattern_sel=1 and frame_cnt=0; animate is absent during blanking.
- pattern_sel=0, btn_prev held across 1 frame -> after BLANK, pattern_sel=2 (wrap); holding the button longer produces no further switch.
- btn_pause press, then 600 frames with auto_en=1 -> paused=1, pattern_sel unchanged, animate never high; a second press resumes counting from the held value.
- btn_speed pressed 7 times from reset -> step_size sequence 2,3,4,5,6,7,1.
- btn_next and btn_prev rising on the same frame -> no BLANK, pattern_sel unchanged, animate pulses normally.
- rst asserted in BLANK frame 1 -> blank=0, pattern_sel=0, step_size=1 immediately. With PATTERN_SCHED_FADE_EN undefined, a btn_next press switches on the same frame_tick.
